// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// wait-counter width and the byte-lane merge used by the storage array.
package mips_pkg;

  localparam int DMEM_WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } t_dmem_state;

  function automatic logic [31:0] dmem_lane_merge(input logic [31:0] old_word,
                                                  input logic [31:0] new_word,
                                                  input logic [3:0]  lane_en);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: one synchronous write port with per-lane
// enables, one combinational read port, every word cleared by reset.
module dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    lane_en_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Storage words with lane-masked writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= dmem_lane_merge(mem_q[waddr_i], wdata_i, lane_en_i);
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts WAIT_CYCLES
// wait states, then holds the response until the core takes it.
// Build option: define DMEM_BYTE_STROBE_EN to honour req_be on stores.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DATA_MEM_DEPTH = 64,
  parameter int WAIT_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DATA_MEM_DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(DATA_MEM_DEPTH * 4);
  localparam logic [DMEM_WAIT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES > 0) ? DMEM_WAIT_W'(WAIT_CYCLES - 1) : {DMEM_WAIT_W{1'b0}};

  t_dmem_state            state_q, state_d;
  logic [DMEM_WAIT_W-1:0] cnt_q, cnt_d;
  logic                   write_q, write_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [3:0]             be_q, be_d;
  logic                   req_ready_q, req_ready_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [31:0]            resp_rdata_q, resp_rdata_d;
  logic                   resp_err_q, resp_err_d;

  logic                   accept_s, enter_resp_s, mem_we_s;
  logic                   op_write_s, op_err_s;
  logic [31:0]            op_addr_s, op_wdata_s;
  logic [3:0]             op_be_s, lane_en_s;
  logic [31:0]            mem_rdata_s;

  // State, latched request and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= {DMEM_WAIT_W{1'b0}};
      write_q      <= 1'b0;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      be_q         <= 4'b0000;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // With zero wait states the response is formed on the accept edge itself,
  // so the operation is taken from the live request rather than the latches.
  always_comb begin
    accept_s   = req_valid & req_ready_q & (state_q == IDLE);
    op_write_s = accept_s ? req_write : write_q;
    op_addr_s  = accept_s ? req_addr  : addr_q;
    op_wdata_s = accept_s ? req_wdata : wdata_q;
    op_be_s    = accept_s ? req_be    : be_q;
    op_err_s   = (op_addr_s[1:0] != 2'b00) || (op_addr_s >= MEM_BYTES);
`ifdef DMEM_BYTE_STROBE_EN
    lane_en_s  = op_be_s;
`else
    lane_en_s  = op_be_s | 4'b1111;
`endif
  end

  // Next-state logic and response capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == {DMEM_WAIT_W{1'b0}}) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - DMEM_WAIT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {DMEM_WAIT_W{1'b0}};
      end
    endcase

    enter_resp_s = (state_d == RESP) && (state_q != RESP);
    mem_we_s     = enter_resp_s & op_write_s & ~op_err_s;
    if (enter_resp_s) begin
      resp_err_d   = op_err_s;
      resp_rdata_d = (op_write_s || op_err_s) ? 32'h0000_0000 : mem_rdata_s;
    end else begin
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
    end
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  dmem_array #(
    .DEPTH (DATA_MEM_DEPTH)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .we_i      (mem_we_s),
    .waddr_i   (op_addr_s[AW+1:2]),
    .wdata_i   (op_wdata_s),
    .lane_en_i (lane_en_s),
    .raddr_i   (op_addr_s[AW+1:2]),
    .rdata_o   (mem_rdata_s)
  );

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 has two wait states,
// instance 1 has none; both share clock and reset.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [3:0]  req_be     [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int checks = 0;
  int passes = 0;

  dmem_responder #(.DATA_MEM_DEPTH(64), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.DATA_MEM_DEPTH(64), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request, wait for accept, then return latency (cycles from the
  // accept cycle to the first cycle with resp_valid) and the response fields.
  task automatic issue(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output int lat, output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req_valid[s] = 1'b1; req_write[s] = w; req_addr[s] = a; req_wdata[s] = d; req_be[s] = be;
    n = 0;
    while (!req_ready[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid[s] = 1'b0;
    lat = 1;
    while (!resp_valid[s] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid[s]) lat = -1;
    rd = resp_rdata[s];
    er = resp_err[s];
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({req_ready[s], resp_valid[s], resp_rdata[s], resp_err[s]} !== 35'd0)
        $display("FAIL reset_outputs dut%0d got ready=%b valid=%b rdata=%h err=%b exp all zero",
                 s, req_ready[s], resp_valid[s], resp_rdata[s], resp_err[s]);
      else passes++;
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (req_ready[s] !== 1'b1)
        $display("FAIL reset_release_ready dut%0d got=%b exp=1", s, req_ready[s]);
      else passes++;
    end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er;
    issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
    checks++; if (lat !== 3) $display("FAIL store_latency got=%0d exp=3", lat); else passes++;
    checks++; if (er !== 1'b0) $display("FAIL store_err got=%b exp=0", er); else passes++;
    checks++; if (rd !== 32'h0) $display("FAIL store_rdata got=%h exp=00000000", rd); else passes++;
    issue(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    checks++; if (lat !== 3) $display("FAIL load_latency got=%0d exp=3", lat); else passes++;
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL load_rdata got=%h exp=deadbeef", rd); else passes++;
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic er; int n;
    resp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL stall_first_rdata got=%h exp=deadbeef", rd); else passes++;
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h14; req_be[0] = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({resp_valid[0], resp_rdata[0], req_ready[0]} !== {1'b1, 32'hDEADBEEF, 1'b0})
        $display("FAIL stall_hold cycle%0d got valid=%b rdata=%h ready=%b exp valid=1 rdata=deadbeef ready=0",
                 i, resp_valid[0], resp_rdata[0], req_ready[0]);
      else passes++;
    end
    resp_ready[0] = 1'b1;
    @(negedge clk);
    checks++;
    if ({resp_valid[0], req_ready[0]} !== 2'b01)
      $display("FAIL after_handshake got valid=%b ready=%b exp valid=0 ready=1", resp_valid[0], req_ready[0]);
    else passes++;
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b0) $display("FAIL next_accept got ready=%b exp=0", req_ready[0]); else passes++;
    req_valid[0] = 1'b0;
    n = 1;
    while (!resp_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({n, resp_rdata[0]} !== {32'd3, 32'h0})
      $display("FAIL queued_load got lat=%0d rdata=%h exp lat=3 rdata=00000000", n, resp_rdata[0]);
    else passes++;
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    issue(0, 1'b0, 32'h13, 32'h0, 4'hF, lat, rd, er);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL misaligned_load got err=%b rdata=%h exp err=1 rdata=0", er, rd); else passes++;
    issue(0, 1'b0, 32'h100, 32'h0, 4'hF, lat, rd, er);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL range_load got err=%b rdata=%h exp err=1 rdata=0", er, rd); else passes++;
    issue(0, 1'b0, 32'hFC, 32'h0, 4'hF, lat, rd, er);
    checks++; if ({er, rd} !== {1'b0, 32'h0}) $display("FAIL last_word_load got err=%b rdata=%h exp err=0 rdata=0", er, rd); else passes++;
    issue(0, 1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, lat, rd, er);
    checks++; if ({er, rd} !== {1'b1, 32'h0}) $display("FAIL misaligned_store got err=%b rdata=%h exp err=1 rdata=0", er, rd); else passes++;
    issue(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    checks++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) $display("FAIL mem_unchanged got err=%b rdata=%h exp err=0 rdata=deadbeef", er, rd); else passes++;
  endtask

  task automatic test_byte_strobe();
    int lat; logic [31:0] rd; logic er; logic [31:0] exp_word;
`ifdef DMEM_BYTE_STROBE_EN
    exp_word = 32'hDE22BE44;
`else
    exp_word = 32'h11223344;
`endif
    issue(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, lat, rd, er);
    issue(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    checks++; if (rd !== exp_word) $display("FAIL byte_strobe got=%h exp=%h", rd, exp_word); else passes++;
  endtask

  task automatic test_zero_wait();
    int lat; logic [31:0] rd; logic er;
    issue(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, lat, rd, er);
    checks++; if ({lat, er} !== {32'd1, 1'b0}) $display("FAIL zw_store got lat=%0d err=%b exp lat=1 err=0", lat, er); else passes++;
    issue(1, 1'b0, 32'h20, 32'h0, 4'hF, lat, rd, er);
    checks++; if ({lat, rd} !== {32'd1, 32'hCAFEF00D}) $display("FAIL zw_load got lat=%0d rdata=%h exp lat=1 rdata=cafef00d", lat, rd); else passes++;
  endtask

  task automatic test_reset_in_wait();
    int lat; logic [31:0] rd; logic er;
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h40; req_wdata[0] = 32'h55AA55AA; req_be[0] = 4'hF;
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ready[0], resp_valid[0], resp_rdata[0], resp_err[0]} !== 35'd0)
      $display("FAIL rst_in_wait got ready=%b valid=%b rdata=%h err=%b exp all zero",
               req_ready[0], resp_valid[0], resp_rdata[0], resp_err[0]);
    else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(0, 1'b0, 32'h40, 32'h0, 4'hF, lat, rd, er);
    checks++; if ({er, rd} !== {1'b0, 32'h0}) $display("FAIL discarded_store got err=%b rdata=%h exp err=0 rdata=0", er, rd); else passes++;
    issue(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, rd, er);
    checks++; if (rd !== 32'h0) $display("FAIL storage_cleared got=%h exp=00000000", rd); else passes++;
  endtask

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_write[s] = 1'b0; req_addr[s] = 32'h0;
      req_wdata[s] = 32'h0; req_be[s] = 4'h0; resp_ready[s] = 1'b1;
    end
    test_reset();
    test_store_load();
    test_backpressure();
    test_errors();
    test_byte_strobe();
    test_zero_wait();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
